// File: rtl/mem_req_scheduler_if.sv
// Bundle of the CPU request/response handshake and the memory-system access bus
// seen by mem_req_scheduler.
interface mem_req_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  MemRead;
    logic                  MemWrite;
    logic [ADDR_WIDTH-1:0] WordAddress;
    logic [DATA_WIDTH-1:0] DataIn;
    logic                  Stall;
    logic [DATA_WIDTH-1:0] DataOut;
    logic [15:0]           stall_cnt;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, Stall, DataOut,
        output req_ready, rsp_valid, rsp_rdata, MemRead, MemWrite,
               WordAddress, DataIn, stall_cnt
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, Stall, DataOut,
        input  req_ready, rsp_valid, rsp_rdata, MemRead, MemWrite,
               WordAddress, DataIn, stall_cnt
    );
endinterface

// File: rtl/mem_req_scheduler.sv
// In-order request FIFO in front of the data memory: issues one access at a time,
// holds it while Stall is high, returns load data and counts stalled cycles.
module mem_req_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 4
) (
    input  logic               CLK,
    input  logic               rst,
    mem_req_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  fifo_we_q    [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q  [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata_q [DEPTH];
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [15:0]           stall_cnt_q;

    logic                  full_s, push_s, pop_s;
    logic                  head_we_s;
    logic [ADDR_WIDTH-1:0] head_addr_s;
    logic [DATA_WIDTH-1:0] head_wdata_s;
    logic                  mem_read_s, mem_write_s;
    logic [ADDR_WIDTH-1:0] word_addr_s;
    logic [DATA_WIDTH-1:0] data_in_s;

    assign full_s       = (count_q == CNT_W'(DEPTH));
    assign push_s       = bus.req_valid && !full_s;
    assign pop_s        = (state_q == S_ISSUE) && !bus.Stall;
    assign head_we_s    = fifo_we_q[rd_ptr_q];
    assign head_addr_s  = fifo_addr_q[rd_ptr_q];
    assign head_wdata_s = fifo_wdata_q[rd_ptr_q];

    // Occupancy after this edge's push and pop.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Stay in ISSUE while work remains so back-to-back requests see no bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != CNT_W'(0)) state_d = S_ISSUE;
                else                      state_d = S_IDLE;
            end
            S_ISSUE: begin
                if (pop_s && (count_d == CNT_W'(0))) state_d = S_IDLE;
                else                                 state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory-side strobes follow the FIFO head while an access is in flight.
    always_comb begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        word_addr_s = '0;
        data_in_s   = '0;
        if (state_q == S_ISSUE) begin
            mem_read_s  = !head_we_s;
            mem_write_s = head_we_s;
            word_addr_s = head_addr_s;
            data_in_s   = head_wdata_s;
        end else begin
            mem_read_s  = 1'b0;
            mem_write_s = 1'b0;
        end
    end

    // FIFO payload storage; contents are only observed through valid entries.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            fifo_we_q[wr_ptr_q]    <= bus.req_we;
            fifo_addr_q[wr_ptr_q]  <= bus.req_addr;
            fifo_wdata_q[wr_ptr_q] <= bus.req_wdata;
        end
    end

    // Control state, pointers, response register and stall counter.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            stall_cnt_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (pop_s && !head_we_s) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= bus.DataOut;
            end else begin
                rsp_valid_q <= 1'b0;
            end
            if ((state_q == S_ISSUE) && bus.Stall && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.req_ready   = !full_s;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.MemRead     = mem_read_s;
    assign bus.MemWrite    = mem_write_s;
    assign bus.WordAddress = word_addr_s;
    assign bus.DataIn      = data_in_s;
    assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_mem_req_scheduler.sv
// Randomized and directed bench for mem_req_scheduler against a queue-based
// transaction model of the request/issue/response rules.
module tb_mem_req_scheduler;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int DEPTH = 4;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    logic clk;
    logic rst;
    mem_req_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_req_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .CLK (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    req_t          mq[$];
    bit            m_busy;
    logic          m_rsp_v;
    logic [DW-1:0] m_rsp_d;
    logic [15:0]   m_cnt;
    bit            rand_dout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the transaction model by one rising edge using the inputs seen there.
    task automatic model_edge();
        bit   done, push, had_work;
        req_t r;
        if (rst) begin
            mq.delete();
            m_busy  = 0;
            m_rsp_v = 1'b0;
            m_rsp_d = '0;
            m_cnt   = 16'h0000;
            return;
        end
        done     = m_busy && !bus.Stall;
        push     = bus.req_valid && (mq.size() < DEPTH);
        had_work = (mq.size() != 0);
        if (done && !mq[0].we) begin
            m_rsp_v = 1'b1;
            m_rsp_d = bus.DataOut;
        end else begin
            m_rsp_v = 1'b0;
        end
        if (m_busy && bus.Stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (done) void'(mq.pop_front());
        if (push) begin
            r.we = bus.req_we; r.addr = bus.req_addr; r.wdata = bus.req_wdata;
            mq.push_back(r);
        end
        if (!m_busy) m_busy = had_work;
        else if (done) m_busy = (mq.size() != 0);
    endtask

    task automatic check_all();
        logic          e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_din = '0;
        if (m_busy && mq.size() != 0) begin
            e_rd = !mq[0].we; e_wr = mq[0].we; e_addr = mq[0].addr; e_din = mq[0].wdata;
        end
        chk("req_ready",   64'(bus.req_ready),   64'(mq.size() < DEPTH));
        chk("MemRead",     64'(bus.MemRead),     64'(e_rd));
        chk("MemWrite",    64'(bus.MemWrite),    64'(e_wr));
        chk("WordAddress", 64'(bus.WordAddress), 64'(e_addr));
        chk("DataIn",      64'(bus.DataIn),      64'(e_din));
        chk("rsp_valid",   64'(bus.rsp_valid),   64'(m_rsp_v));
        chk("rsp_rdata",   64'(bus.rsp_rdata),   64'(m_rsp_d));
        chk("stall_cnt",   64'(bus.stall_cnt),   64'(m_cnt));
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        if (rand_dout) bus.DataOut = $urandom;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.Stall  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic push_one(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic scen_single_load();
        rand_dout = 0;
        bus.DataOut = 32'hDEADBEEF;
        bus.Stall = 1'b0;
        push_one(1'b0, 10'h005, 32'h0);
        step();
        chk("s1_memread", 64'(bus.MemRead), 64'd1);
        chk("s1_addr", 64'(bus.WordAddress), 64'h005);
        step();
        chk("s1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("s1_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        chk("s1_memread_off", 64'(bus.MemRead), 64'd0);
        step();
        chk("s1_rsp_pulse", 64'(bus.rsp_valid), 64'd0);
        chk("s1_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        rand_dout = 1;
    endtask

    initial begin
        int a, n_rsp;
        bit acc;
        rst = 1'b1;
        rand_dout = 1;
        bus.DataOut = '0;
        idle_inputs();
        m_busy = 0; m_rsp_v = 1'b0; m_rsp_d = '0; m_cnt = 16'h0;
        do_reset();
        chk("rst_ready", 64'(bus.req_ready), 64'd1);

        // Single load, no stall.
        scen_single_load();

        // Store held through three stalled cycles.
        do_reset();
        push_one(1'b1, 10'h010, 32'h12345678);
        bus.Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s2_hold_addr", 64'(bus.WordAddress), 64'h010);
            chk("s2_hold_data", 64'(bus.DataIn), 64'h12345678);
        end
        bus.Stall = 1'b0;
        step();
        chk("s2_stall_cnt", 64'(bus.stall_cnt), 64'd3);
        chk("s2_no_rsp", 64'(bus.rsp_valid), 64'd0);

        // Five loads into a four-deep FIFO while stalled, then drain.
        do_reset();
        bus.Stall = 1'b1;
        a = 1;
        n_rsp = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 12) begin
                chk("s3_full", 64'(bus.req_ready), 64'd0);
                bus.Stall = 1'b0;
            end
            bus.req_valid = (a <= 5); bus.req_we = 1'b0; bus.req_addr = AW'(a);
            acc = bus.req_valid && (mq.size() < DEPTH);
            step();
            if (acc) a++;
            if (bus.rsp_valid) n_rsp++;
        end
        chk("s3_rsp_count", 64'(n_rsp), 64'd5);

        // Store then load to the same address.
        do_reset();
        n_rsp = 0;
        push_one(1'b1, 10'h020, 32'hAAAA0000);
        push_one(1'b0, 10'h020, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.rsp_valid) n_rsp++;
        end
        chk("s4_rsp_count", 64'(n_rsp), 64'd1);

        // Reset during a stalled load with two entries behind it.
        do_reset();
        bus.Stall = 1'b1;
        push_one(1'b0, 10'h031, 32'h0);
        push_one(1'b0, 10'h032, 32'h0);
        push_one(1'b0, 10'h033, 32'h0);
        step();
        chk("s5_busy", 64'(bus.MemRead), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("s5_async_rd", 64'(bus.MemRead), 64'd0);
        chk("s5_async_addr", 64'(bus.WordAddress), 64'd0);
        chk("s5_async_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("s5_async_ready", 64'(bus.req_ready), 64'd1);
        idle_inputs();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        scen_single_load();

        // Stall counter saturation.
        do_reset();
        push_one(1'b0, 10'h044, 32'h0);
        bus.Stall = 1'b1;
        for (int i = 0; i < 65541; i++) step();
        chk("s6_saturated", 64'(bus.stall_cnt), 64'hFFFF);
        bus.Stall = 1'b0;
        step();
        step();

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.req_valid = ($urandom_range(0, 99) < 55);
            bus.req_we    = $urandom_range(0, 1);
            bus.req_addr  = AW'($urandom);
            bus.req_wdata = $urandom;
            bus.Stall     = ($urandom_range(0, 99) < 35);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
